// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-controller definitions: default address width, boot PC and
// the fetch FSM state encoding.
package fetch_ctrl_pkg;

  localparam int unsigned CPU_WIDTH_DEF = 64;
  localparam logic [63:0] RESET_PC_DEF  = 64'h0000_0000_8000_0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_OUT   = 3'd3,
    ST_FLUSH = 3'd4,
    ST_HALT  = 3'd5
  } state_e;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues one imem request at a time, hands the
// fetched word to decode, and handles redirects, flushes and ebreak halt.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned           CPU_WIDTH = CPU_WIDTH_DEF,
  parameter logic [CPU_WIDTH-1:0]  RESET_PC  = RESET_PC_DEF[CPU_WIDTH-1:0]
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 redirect_valid,
  input  logic [CPU_WIDTH-1:0] redirect_pc,
  input  logic                 ebreak_flag,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [CPU_WIDTH-1:0] imem_req_addr,
  input  logic                 imem_rsp_valid,
  input  logic [31:0]          imem_rsp_data,
  output logic                 if_valid,
  input  logic                 if_ready,
  output logic [CPU_WIDTH-1:0] if_pc,
  output logic [31:0]          if_instr,
  output logic                 halted
);

  state_e                 state_q, state_d;
  logic [CPU_WIDTH-1:0]   pc_q, pc_d;
  logic [CPU_WIDTH-1:0]   pend_pc_q, pend_pc_d;
  logic                   pend_q, pend_d;
  logic [31:0]            instr_q, instr_d;
  logic [CPU_WIDTH-1:0]   redir_tgt;

  function automatic logic [CPU_WIDTH-1:0] align_word(input logic [CPU_WIDTH-1:0] a);
    return {a[CPU_WIDTH-1:2], 2'b00};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
      instr_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
      instr_q   <= instr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    instr_d   = instr_q;
    redir_tgt = align_word(redirect_pc);

    // ebreak wins over everything, including a redirect in the same cycle
    if (ebreak_flag) begin
      state_d = ST_HALT;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (redirect_valid) pc_d = redir_tgt;
          state_d = ST_REQ;
        end
        ST_REQ: begin
          if (redirect_valid) begin
            pend_pc_d = redir_tgt;
            pend_d    = 1'b1;
          end
          if (imem_req_ready) begin
            state_d = (pend_q || redirect_valid) ? ST_FLUSH : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (redirect_valid) begin
            if (imem_rsp_valid) begin
              pc_d    = redir_tgt;
              pend_d  = 1'b0;
              state_d = ST_REQ;
            end else begin
              pend_pc_d = redir_tgt;
              pend_d    = 1'b1;
              state_d   = ST_FLUSH;
            end
          end else if (imem_rsp_valid) begin
            instr_d = imem_rsp_data;
            state_d = ST_OUT;
          end
        end
        ST_OUT: begin
          if (redirect_valid) begin
            pc_d    = redir_tgt;
            state_d = ST_REQ;
          end else if (if_ready) begin
            pc_d    = pc_q + CPU_WIDTH'(4);
            state_d = ST_REQ;
          end
        end
        ST_FLUSH: begin
          // A redirect coinciding with the stale response is the newest target
          if (redirect_valid) pend_pc_d = redir_tgt;
          if (imem_rsp_valid) begin
            pc_d    = redirect_valid ? redir_tgt : pend_pc_q;
            pend_d  = 1'b0;
            state_d = ST_REQ;
          end
        end
        ST_HALT: state_d = ST_HALT;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign imem_req_valid = (state_q == ST_REQ);
  assign imem_req_addr  = pc_q;
  assign if_valid       = (state_q == ST_OUT);
  assign if_pc          = pc_q;
  assign if_instr       = instr_q;
  assign halted         = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a memory responder, an architectural PC
// model and a negedge monitor that checks requests, handoffs and halt.
module tb_fetch_ctrl;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        ebreak_flag = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        halted;

  fetch_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ebreak_flag    (ebreak_flag),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          dly;
  } rsp_t;

  rsp_t        pend_q[$];
  logic [63:0] req_exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          handoff_cnt = 0;
  int          accept_cnt = 0;
  int          lat_min = 0;
  int          lat_max = 0;
  logic [63:0] exp_pc = RESET_PC;
  logic        halted_m = 1'b0;
  logic        req_hold = 1'b0;
  logic        out_hold = 1'b0;
  logic [63:0] hold_addr = '0;
  logic [63:0] hold_pc = '0;
  logic [31:0] hold_instr = '0;

  function automatic logic [31:0] mem(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one cycle; drive the memory response for the new cycle
  task automatic step();
    rsp_t t;
    @(posedge clk);
    #1;
    imem_rsp_data = $urandom;
    imem_rsp_valid = 1'b0;
    if (pend_q.size() > 0) begin
      t = pend_q[0];
      if (t.dly == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = t.data;
        void'(pend_q.pop_front());
      end else begin
        t.dly = t.dly - 1;
        pend_q[0] = t;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    ebreak_flag = 1'b0;
    imem_req_ready = 1'b0;
    if_ready = 1'b0;
    step();
    pend_q.delete();
    req_exp_q.delete();
    imem_rsp_valid = 1'b0;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_halted", halted, 0);
    step();
    rst = 1'b0;
    chk("post_rst_req_valid", imem_req_valid, 0);
    chk("post_rst_if_valid", if_valid, 0);
    chk("post_rst_halted", halted, 0);
  endtask

  task automatic wait_ho(input int target, input string name);
    for (int i = 0; i < 80; i++) begin
      if (handoff_cnt >= target) break;
      step();
    end
    chk(name, (handoff_cnt >= target), 1);
  endtask

  // Monitor and architectural model: the next handed-off PC is the last
  // redirect target (word aligned) or the previous handoff plus four.
  always @(negedge clk) begin
    logic [63:0] e;
    rsp_t r;
    if (rst) begin
      exp_pc   = RESET_PC;
      halted_m = 1'b0;
      req_hold = 1'b0;
      out_hold = 1'b0;
    end else begin
      if (halted_m) begin
        chk("halt_flag", halted, 1);
        chk("halt_req_valid", imem_req_valid, 0);
        chk("halt_if_valid", if_valid, 0);
      end
      if (req_hold) begin
        chk("req_hold_valid", imem_req_valid, 1);
        chk("req_hold_addr", imem_req_addr, hold_addr);
      end
      if (out_hold) begin
        chk("out_hold_valid", if_valid, 1);
        chk("out_hold_pc", if_pc, hold_pc);
        chk("out_hold_instr", if_instr, hold_instr);
      end
      req_hold   = imem_req_valid && !imem_req_ready && !ebreak_flag;
      hold_addr  = imem_req_addr;
      out_hold   = if_valid && !if_ready && !redirect_valid && !ebreak_flag;
      hold_pc    = if_pc;
      hold_instr = if_instr;
      if (imem_req_valid && imem_req_ready) begin
        accept_cnt++;
        r.data = mem(imem_req_addr);
        r.dly  = $urandom_range(lat_max, lat_min);
        pend_q.push_back(r);
        if (req_exp_q.size() > 0) begin
          e = req_exp_q.pop_front();
          chk("req_addr", imem_req_addr, e);
        end
      end
      if (!halted_m) begin
        if (ebreak_flag) begin
          halted_m = 1'b1;
        end else if (redirect_valid) begin
          exp_pc = redirect_pc & ~64'h3;
        end else if (if_valid && if_ready) begin
          chk("handoff_pc", if_pc, exp_pc);
          chk("handoff_instr", {32'h0, if_instr}, {32'h0, mem(exp_pc)});
          handoff_cnt++;
          exp_pc = exp_pc + 64'd4;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int base_acc;
    logic [31:0] r;

    // Straight-line fetch, latency 1
    lat_min = 0; lat_max = 0;
    do_reset();
    imem_req_ready = 1'b1;
    if_ready = 1'b1;
    req_exp_q.push_back(64'h8000_0000);
    req_exp_q.push_back(64'h8000_0004);
    req_exp_q.push_back(64'h8000_0008);
    base = handoff_cnt;
    wait_ho(base + 3, "t1_handoffs");
    chk("t1_reqs_seen", req_exp_q.size(), 0);

    // Redirect while the request is stalled
    do_reset();
    req_exp_q.push_back(64'h8000_0000);
    req_exp_q.push_back(64'h8000_0100);
    if_ready = 1'b1;
    base = handoff_cnt;
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0100;
    step();
    redirect_valid = 1'b0;
    chk("t2_addr_stable", imem_req_addr, 64'h8000_0000);
    step();
    imem_req_ready = 1'b1;
    wait_ho(base + 1, "t2_handoff");
    chk("t2_reqs_seen", req_exp_q.size(), 0);

    // Redirect in OUT beats handoff
    do_reset();
    imem_req_ready = 1'b1;
    if_ready = 1'b1;
    for (int i = 0; i < 20 && !if_valid; i++) step();
    chk("t3_reach_out", if_valid, 1);
    base = handoff_cnt;
    req_exp_q.push_back(64'h8000_0200);
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0203;
    step();
    redirect_valid = 1'b0;
    chk("t3_no_handoff", handoff_cnt, base);
    chk("t3_req_valid", imem_req_valid, 1);
    chk("t3_req_addr", imem_req_addr, 64'h8000_0200);
    wait_ho(base + 1, "t3_handoff");

    // Two redirects while flushing; last target wins
    lat_min = 3; lat_max = 3;
    do_reset();
    req_exp_q.push_back(64'h8000_0000);
    req_exp_q.push_back(64'h8000_0080);
    imem_req_ready = 1'b1;
    if_ready = 1'b1;
    base = handoff_cnt;
    step();
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0010;
    step();
    redirect_pc = 64'h8000_0040;
    step();
    redirect_pc = 64'h8000_0080;
    step();
    redirect_valid = 1'b0;
    wait_ho(base + 1, "t4_handoff");
    chk("t4_reqs_seen", req_exp_q.size(), 0);

    // ebreak with redirect in WAIT
    lat_min = 2; lat_max = 2;
    do_reset();
    imem_req_ready = 1'b1;
    if_ready = 1'b1;
    step();
    step();
    ebreak_flag = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0400;
    base = handoff_cnt;
    base_acc = accept_cnt;
    step();
    ebreak_flag = 1'b0;
    redirect_valid = 1'b0;
    chk("t5_halted", halted, 1);
    chk("t5_req_valid", imem_req_valid, 0);
    repeat (6) step();
    chk("t5_no_handoff", handoff_cnt, base);
    chk("t5_no_accept", accept_cnt, base_acc);
    chk("t5_still_halted", halted, 1);

    // Reset pulse while waiting; stale response lands in IDLE
    lat_min = 1; lat_max = 1;
    do_reset();
    imem_req_ready = 1'b1;
    if_ready = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    imem_rsp_data = 32'hDEAD_BEEF;
    chk("t6_stale_delivered", imem_rsp_valid, 1);
    rst = 1'b0;
    base = handoff_cnt;
    req_exp_q.push_back(64'h8000_0000);
    chk("t6_idle_req_valid", imem_req_valid, 0);
    chk("t6_idle_if_valid", if_valid, 0);
    step();
    chk("t6_first_addr", imem_req_addr, 64'h8000_0000);
    wait_ho(base + 1, "t6_handoff");

    // Randomized traffic against the architectural model
    lat_min = 0; lat_max = 2;
    do_reset();
    base = handoff_cnt;
    for (int c = 0; c < 3000; c++) begin
      step();
      imem_req_ready = ($urandom % 4) != 0;
      if_ready = ($urandom % 3) != 0;
      redirect_valid = ($urandom % 10) == 0;
      r = $urandom;
      if ((r % 8) == 0)
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | {60'h0, r[7:4]};
      else
        redirect_pc = RESET_PC + {52'h0, r[15:4]};
    end
    step();
    redirect_valid = 1'b0;
    ebreak_flag = 1'b1;
    step();
    ebreak_flag = 1'b0;
    chk("rnd_halted", halted, 1);
    repeat (5) step();
    chk("rnd_progress", (handoff_cnt - base) > 100, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter CPU_WIDTH, default from shared defines (64), SHALL set the PC/address width.
REQ-002 Parameter RESET_PC, default 64'h8000_0000, SHALL be the fetch address after reset.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 redirect_valid  in  1  one-cycle pulse from the next-PC select: the PC is taken from redirect_pc (branch/jal/jalr).
REQ-006 redirect_pc  in  CPU_WIDTH  redirect target.
REQ-007 ebreak_flag  in  1  halt request.
REQ-008 imem_req_valid  out  1; imem_req_ready  in  1; imem_req_addr  out  CPU_WIDTH  instruction-memory request channel.
REQ-009 imem_rsp_valid  in  1; imem_rsp_data  in  32  response; no backpressure, so the response is consumed in the cycle it is valid.
REQ-010 if_valid  out  1; if_ready  in  1; if_pc  out  CPU_WIDTH; if_instr  out  32  fetched-instruction handoff to decode.
REQ-011 halted  out  1  high while stopped by ebreak.

Function
REQ-012 The FSM SHALL have states IDLE, REQ, WAIT, OUT, FLUSH and HALT; at most one imem request is outstanding.
REQ-013 IDLE SHALL go to REQ unconditionally after one cycle.
REQ-014 REQ: imem_req_valid=1 and imem_req_addr=pc; addr SHALL stay stable until imem_req_ready.
REQ-015 REQ: on imem_req_ready, the FSM SHALL go to WAIT, or to FLUSH if a redirect is pending.
REQ-016 WAIT: on imem_rsp_valid, the FSM SHALL capture imem_rsp_data into if_instr and go to OUT.
REQ-017 OUT: if_valid=1, with if_pc=pc and if_instr stable until if_ready.
REQ-018 OUT: on if_ready, pc SHALL become pc+4 (modulo 2^CPU_WIDTH) and the FSM SHALL go to REQ.
REQ-019 Redirect in REQ before acceptance: target SHALL be latched in pend_pc and pend set; addr unchanged.
REQ-020 Redirect in REQ with imem_req_ready in the same cycle: the FSM SHALL go to FLUSH, with the target latched.
REQ-021 Redirect in WAIT: target SHALL be latched and the FSM SHALL go to FLUSH, or directly to REQ if imem_rsp_valid arrives the same cycle; that response is dropped.
REQ-022 Redirect in OUT: the held instruction SHALL be dropped, pc set to the target, and the FSM go to REQ, even if if_ready is high that cycle; redirect has priority over handoff.
REQ-023 FLUSH: on imem_rsp_valid, the response SHALL be discarded, pc set to pend_pc, pend cleared, and the FSM go to REQ.
REQ-024 A redirect arriving in FLUSH SHALL overwrite pend_pc; the last target wins.
REQ-025 A redirect in IDLE SHALL set pc to the target directly.
REQ-026 Redirect targets SHALL have bits [1:0] forced to 0.
REQ-027 Redirect latency: a redirect in OUT at cycle N SHALL give imem_req_valid with the new address at N+1.
REQ-028 ebreak_flag in any state SHALL force HALT next cycle, overriding redirect; HALT deasserts all valids, sets halted=1, and ignores responses.
REQ-029 HALT SHALL be left only via rst.
REQ-030 if_valid and imem_req_valid SHALL be driven only from state, with no combinational path from any input.

Reset
REQ-031 On rst: state=IDLE, pc=RESET_PC, pend=0, pend_pc=0, if_instr=0.
REQ-032 During rst and the cycle after: imem_req_valid=0, if_valid=0, halted=0.
REQ-033 rst asserted mid-transaction SHALL abandon any outstanding request.
REQ-034 A response arriving in IDLE after reset SHALL be ignored.

Structure
REQ-035 CPU_WIDTH, RESET_PC and the state encoding SHALL live in the shared rvseed defines file.
REQ-036 The design SHALL be a single module with no sub-modules; the +4 adder is inline.

Verification
REQ-037 Reset release, imem_req_ready=1, response latency 1, if_ready=1: requests SHALL issue at 0x8000_0000, 0x8000_0004, 0x8000_0008; if_pc SHALL match each address.
REQ-038 imem_req_ready held low 3 cycles with a redirect to 0x8000_0100 in the 2nd cycle: addr SHALL stay 0x8000_0000, the response SHALL be dropped, and the next request SHALL be 0x8000_0100.
REQ-039 Redirect to 0x8000_0203 while in OUT with if_ready=1: the instruction SHALL not be counted as handed off, and the next addr SHALL be 0x8000_0200 one cycle later.
REQ-040 Two redirects in FLUSH (0x8000_0040 then 0x8000_0080): the next addr SHALL be 0x8000_0080.
REQ-041 ebreak_flag together with redirect_valid in WAIT: halted=1 next cycle, no further requests, and a later response ignored.
REQ-042 rst pulsed while in WAIT: the response SHALL be ignored and the first request after reset SHALL be 0x8000_0000.
